dsc_serial_mul_ctrl: RTL and testbench

Parametrised deterministic-stochastic-computing multiplier for NUM_INPUTS unsigned operands of DATA_WIDTH bits each.
- Each operand drives a unary stochastic number generator.
- Channels are clock-divided by enable chaining (channel i advances only when channel i-1 wraps), all on one clock domain with no derived clocks.
- The AND of all streams is counted to give the exact product.
- Adds a start/busy/done handshake, operand latching and an optional early-termination mode.
- Sits between binary datapath logic and DSC arithmetic sweeps as a drop-in exact multiplier with bounded, data-dependent latency.

---
 rtl/dsc_pkg.sv | 19 +
 rtl/sng_dsc_chain.sv | 30 +++
 rtl/dsc_serial_mul_ctrl.sv | 125 ++++++++++++
 tb/tb_dsc_serial_mul_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// Shared types and sizing helpers for the deterministic stochastic multiplier.
package dsc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int out_width(input int w, input int n);
    return w * n;
  endfunction

  // Number of RUN cycles in early-termination mode for a given last operand.
  function automatic longint early_len(input int a_last, input int w, input int n);
    return longint'(a_last) << (w * (n - 1));
  endfunction

endpackage

// File: rtl/sng_dsc_chain.sv
// One unary stochastic number generator channel: a wrapping counter compared
// against the latched operand, plus the wrap strobe used to enable the next channel.
module sng_dsc_chain #(
  parameter int DATA_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [DATA_WIDTH-1:0] bin_in,
  output logic                  sn_out,
  output logic                  wrap,
  output logic [DATA_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + DATA_WIDTH'(1);
    end
  end

  // A max-valued operand still emits 0 when the counter sits at max.
  assign sn_out = (count < bin_in);
  assign wrap   = inc & (&count);

endmodule

// File: rtl/dsc_serial_mul_ctrl.sv
// Exact multiplier built from chained unary SNGs; the AND of all streams is
// counted over the sweep. Wrapped in a start/busy/done controller.
module dsc_serial_mul_ctrl
  import dsc_pkg::*;
#(
  parameter  int DATA_WIDTH = 5,
  parameter  int NUM_INPUTS = 2,
  localparam int OUT_WIDTH  = out_width(DATA_WIDTH, NUM_INPUTS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  early_en,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] bin_data_in,
  output logic                                  busy,
  output logic                                  done,
  output logic [OUT_WIDTH-1:0]                  bin_data_out,
  output state_t                                dbg_state
);

  // Handshake: start is taken only while IDLE (no busy, no done); busy rises the
  // cycle after acceptance, done pulses once with bin_data_out valid and held
  // until the next accepted start. start in RUN/DONE is ignored.

  state_t                                state;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] a_q;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] cnt;
  logic [NUM_INPUTS-1:0]                 sn;
  logic [NUM_INPUTS-1:0]                 wrap;
  logic [NUM_INPUTS-1:0]                 inc;
  logic                                  early_q;
  logic [OUT_WIDTH-1:0]                  acc;
  logic                                  clr;
  logic                                  hit;
  logic                                  any_zero;
  logic                                  last_full;
  logic                                  last_early;
  logic                                  last;

  assign clr    = (state == S_IDLE) && start;
  assign inc[0] = (state == S_RUN);

  genvar gi;
  generate
    for (gi = 1; gi < NUM_INPUTS; gi++) begin : g_inc
      assign inc[gi] = inc[gi-1] & wrap[gi-1];
    end
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
      sng_dsc_chain #(.DATA_WIDTH(DATA_WIDTH)) u_chan (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .inc    (inc[gi]),
        .bin_in (a_q[gi]),
        .sn_out (sn[gi]),
        .wrap   (wrap[gi]),
        .count  (cnt[gi])
      );
    end
  endgenerate

  assign hit       = &sn;
  assign last_full = wrap[NUM_INPUTS-1];
  // Once the top channel has passed a[N-1] its stream is all zeros, so stop there.
  assign last_early = inc[NUM_INPUTS-1] &&
                      (cnt[NUM_INPUTS-1] == a_q[NUM_INPUTS-1] - DATA_WIDTH'(1));
  assign last       = early_q ? last_early : last_full;

  always_comb begin
    any_zero = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (bin_data_in[i] == '0) any_zero = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      bin_data_out <= '0;
      acc          <= '0;
      a_q          <= '0;
      early_q      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q     <= bin_data_in;
            early_q <= early_en;
            acc     <= '0;
            if (early_en && any_zero) begin
              state        <= S_DONE;
              done         <= 1'b1;
              bin_data_out <= '0;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          acc <= acc + OUT_WIDTH'(hit);
          if (last) begin
            state        <= S_DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            bin_data_out <= acc + OUT_WIDTH'(hit);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_dsc_serial_mul_ctrl.sv
// Directed bench for dsc_serial_mul_ctrl: a W=3/N=2 and a W=3/N=3 instance,
// table-driven product/latency vectors plus reset and handshake sequences.
module tb_dsc_serial_mul_ctrl;
  import dsc_pkg::*;

  localparam int BUDGET = 700;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;

  logic             start2 = 1'b0;
  logic             early2 = 1'b0;
  logic [1:0][2:0]  din2 = '0;
  logic             busy2;
  logic             done2;
  logic [5:0]       out2;
  state_t           st2;

  logic             start3 = 1'b0;
  logic             early3 = 1'b0;
  logic [2:0][2:0]  din3 = '0;
  logic             busy3;
  logic             done3;
  logic [8:0]       out3;
  state_t           st3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dsc_serial_mul_ctrl #(.DATA_WIDTH(3), .NUM_INPUTS(2)) u_dut2 (
    .clk(clk), .rst(rst_n), .start(start2), .early_en(early2),
    .bin_data_in(din2), .busy(busy2), .done(done2),
    .bin_data_out(out2), .dbg_state(st2)
  );

  dsc_serial_mul_ctrl #(.DATA_WIDTH(3), .NUM_INPUTS(3)) u_dut3 (
    .clk(clk), .rst(rst_n), .start(start3), .early_en(early3),
    .bin_data_in(din3), .busy(busy3), .done(done3),
    .bin_data_out(out3), .dbg_state(st3)
  );

  typedef struct {
    int sel;
    int x0;
    int x1;
    int x2;
    bit e;
    int poke;
    int exp_lat;
    int exp_busy;
    int exp_res;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic cur_done(input int sel);
    return (sel == 3) ? done3 : done2;
  endfunction

  function automatic logic cur_busy(input int sel);
    return (sel == 3) ? busy3 : busy2;
  endfunction

  function automatic int cur_out(input int sel);
    return (sel == 3) ? int'(out3) : int'(out2);
  endfunction

  task automatic drive(input int sel, input int x0, input int x1, input int x2,
                       input bit e, input bit s);
    if (sel == 3) begin
      din3[0] = 3'(x0); din3[1] = 3'(x1); din3[2] = 3'(x2);
      early3 = e; start3 = s;
    end else begin
      din2[0] = 3'(x0); din2[1] = 3'(x1);
      early2 = e; start2 = s;
    end
  endtask

  task automatic set_start(input int sel, input bit s);
    if (sel == 3) start3 = s; else start2 = s;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge one cycle after done.
  task automatic run_vec(input string tag, input vec_t v, input bit start_in_done);
    int edges;
    int busy_n;
    int hold_bad;
    int prev;
    int res;
    prev = cur_out(v.sel);
    drive(v.sel, v.x0, v.x1, v.x2, v.e, 1'b1);
    @(posedge clk); @(negedge clk);
    set_start(v.sel, 1'b0);
    edges = 1; busy_n = 0; hold_bad = 0;
    while (!cur_done(v.sel) && edges < BUDGET) begin
      if (cur_busy(v.sel)) busy_n++;
      if (cur_out(v.sel) != prev) hold_bad++;
      if (v.poke != 0 && edges == v.poke) drive(v.sel, 1, 1, 1, 1'b1, 1'b1);
      else if (v.poke != 0 && edges == v.poke + 1) set_start(v.sel, 1'b0);
      @(posedge clk); @(negedge clk);
      edges++;
    end
    res = cur_out(v.sel);
    check({tag, " latency"}, edges, v.exp_lat);
    check({tag, " busy_cycles"}, busy_n, v.exp_busy);
    check({tag, " product"}, res, v.exp_res);
    check({tag, " output_held"}, hold_bad, 0);
    check({tag, " busy_at_done"}, cur_busy(v.sel), 0);
    if (start_in_done) drive(v.sel, 1, 1, 1, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    set_start(v.sel, 1'b0);
    check({tag, " done_pulse"}, cur_done(v.sel), 0);
    check({tag, " result_after_done"}, cur_out(v.sel), v.exp_res);
    if (start_in_done) begin
      @(posedge clk); @(negedge clk);
      check({tag, " start_in_done_busy"}, cur_busy(v.sel), 0);
      check({tag, " start_in_done_done"}, cur_done(v.sel), 0);
    end
  endtask

  initial begin
    int done_seen;
    vec_t v;

    vecs[0] = '{2, 5, 6, 0, 1'b0, 0, 65, 64, 30};
    vecs[1] = '{2, 5, 6, 0, 1'b1, 0, 49, 48, 30};
    vecs[2] = '{2, 0, 4, 0, 1'b1, 0, 1, 0, 0};
    vecs[3] = '{2, 0, 4, 0, 1'b0, 0, 65, 64, 0};
    vecs[4] = '{3, 7, 7, 7, 1'b0, 10, 513, 512, 343};
    vecs[5] = '{2, 7, 7, 0, 1'b1, 0, 57, 56, 49};
    vecs[6] = '{2, 3, 2, 0, 1'b0, 0, 65, 64, 6};
    vecs[7] = '{3, 3, 5, 2, 1'b1, 0, 129, 128, 30};
    vecs[8] = '{2, 1, 1, 0, 1'b1, 0, 9, 8, 1};
    vecs[9] = '{3, 7, 0, 7, 1'b1, 0, 1, 0, 0};

    repeat (3) @(negedge clk);
    check("reset busy2", busy2, 0);
    check("reset done2", done2, 0);
    check("reset out2", out2, 0);
    check("reset out3", out3, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle state2", st2, S_IDLE);

    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i], 1'b0);
    end

    // Asynchronous reset partway through a full-mode run.
    drive(2, 5, 6, 0, 1'b0, 1'b1);
    @(posedge clk); @(negedge clk);
    set_start(2, 1'b0);
    repeat (19) @(negedge clk);
    check("pre_reset busy", busy2, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset busy", busy2, 0);
    check("async_reset done", done2, 0);
    check("async_reset out", out2, 0);
    check("async_reset state", st2, S_IDLE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (done2) done_seen++;
    end
    check("no_done_after_abort", done_seen, 0);
    v = '{2, 3, 2, 0, 1'b0, 0, 65, 64, 6};
    run_vec("post_reset", v, 1'b0);

    // Back-to-back: second start lands the cycle after done; first has start in DONE.
    v = '{2, 5, 6, 0, 1'b1, 0, 49, 48, 30};
    run_vec("b2b_first", v, 1'b1);
    v = '{2, 3, 2, 0, 1'b0, 0, 65, 64, 6};
    run_vec("b2b_second", v, 1'b0);
    v = '{2, 7, 6, 0, 1'b0, 0, 65, 64, 42};
    run_vec("b2b_third", v, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
